// File: rtl/div_seq_pkg.sv
// Shared constants for the iterative divider: state codes, handshake levels
// and the EX aluop codes that launch a divide.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam int DOUBLE_REG_W = 64;

    // aluop codes EX decodes to raise start_i
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: compare the upper window against the
// divisor, keep the difference and shift in a 1, or just shift (restore).
module div_step
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [2*DATA_W:0] o_dividend
);

    logic [DATA_W:0] w_diff;

    assign w_diff = {1'b0, i_dividend[2*DATA_W-1:DATA_W]} - {1'b0, i_divisor};

    always_comb begin
        o_dividend = {i_dividend[2*DATA_W-1:0], 1'b0};
        if (!w_diff[DATA_W])
            o_dividend = {w_diff[DATA_W-1:0], i_dividend[DATA_W-1:0], 1'b1};
    end

endmodule

// File: rtl/div_seq.sv
// Iterative divider sequencer beside EX: one quotient bit per clock on operand
// magnitudes, sign correction at the end, result held until EX drops start_i.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    div_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*DATA_W:0] r_dividend;
    logic [DATA_W-1:0] r_divisor;
    logic              r_neg_q;
    logic              r_neg_r;

    logic [DATA_W-1:0] w_one;
    logic              w_sign1;
    logic              w_sign2;
    logic [DATA_W-1:0] w_op1_abs;
    logic [DATA_W-1:0] w_op2_abs;
    logic [2*DATA_W:0] w_next_dividend;
    logic [DATA_W-1:0] w_quot;
    logic [DATA_W-1:0] w_rem;
    logic              w_go;

    assign w_one     = {{(DATA_W-1){1'b0}}, 1'b1};
    assign w_sign1   = signed_div_i & opdata1_i[DATA_W-1];
    assign w_sign2   = signed_div_i & opdata2_i[DATA_W-1];
    assign w_op1_abs = w_sign1 ? (~opdata1_i + w_one) : opdata1_i;
    assign w_op2_abs = w_sign2 ? (~opdata2_i + w_one) : opdata2_i;
    assign w_go      = (start_i == DIV_START) && !annul_i;

    // Sign fix-up: quotient follows sign1^sign2, remainder follows the dividend.
    assign w_quot = r_neg_q ? (~r_dividend[DATA_W-1:0] + w_one) : r_dividend[DATA_W-1:0];
    assign w_rem  = r_neg_r ? (~r_dividend[2*DATA_W:DATA_W+1] + w_one)
                            : r_dividend[2*DATA_W:DATA_W+1];

    assign busy_o = (r_state != DIV_FREE) || w_go;

    div_step #(.DATA_W(DATA_W)) u_step (
        .i_dividend (r_dividend),
        .i_divisor  (r_divisor),
        .o_dividend (w_next_dividend)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_FREE;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            result_o   <= '0;
            ready_o    <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (w_go) begin
                        if (opdata2_i == '0) begin
                            r_state <= DIV_BY_ZERO;
                        end else begin
                            r_state    <= DIV_ON;
                            r_cnt      <= '0;
                            r_dividend <= {{DATA_W{1'b0}}, w_op1_abs, 1'b0};
                            r_divisor  <= w_op2_abs;
                            r_neg_q    <= w_sign1 ^ w_sign2;
                            r_neg_r    <= w_sign1;
                        end
                    end
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= '0;
                end
                DIV_BY_ZERO: begin
                    r_state    <= DIV_END;
                    r_dividend <= '0;
                    result_o   <= '0;
                    ready_o    <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_W'(DATA_W)) begin
                        r_dividend <= w_next_dividend;
                        r_cnt      <= r_cnt + 1'b1;
                    end else begin
                        r_state  <= DIV_END;
                        r_cnt    <= '0;
                        result_o <= {w_rem, w_quot};
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    // Flushes are ignored here; EX ends the op by dropping start_i.
                    if (start_i == DIV_STOP) begin
                        r_state  <= DIV_FREE;
                        ready_o  <= DIV_RESULT_NOT_READY;
                        result_o <= '0;
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide by
// zero, annul and mid-operation reset, all against hand-computed values.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_chk;
    int n_err;

    div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Launch a divide, count edges (start-sampling edge = 1) until ready_o,
    // check result, hold one more cycle, then drop start_i and check FREE.
    task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
        int  n;
        logic busy_ok;
        @(negedge clk);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        #1 chk({tag, "_busy0"}, {63'd0, busy_o}, 64'd1);
        n       = 0;
        busy_ok = 1'b1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy_o) busy_ok = 1'b0;
            if (ready_o) break;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, {62'd0, ready_o, busy_o}, 64'd0);
        chk({tag, "_clr"}, result_o, 64'd0);
    endtask

    initial begin
        logic seen;
        n_chk        = 0;
        n_err        = 0;
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst", {ready_o, busy_o, result_o[61:0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div("u7d2",   1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 34);
        do_div("sm7d2",  1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34);
        do_div("s7dm2",  1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        do_div("dz",     1'b0, 32'h12345678, 32'd0,        64'd0,                 2);
        do_div("smin",   1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        do_div("zero",   1'b0, 32'd0,        32'd5,        64'd0,                 34);

        // annul mid-operation
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("annul", {62'd0, ready_o, busy_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        seen    = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        chk("annul_quiet", {63'd0, seen}, 64'd0);
        do_div("u100d7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

        // reset mid-operation
        @(negedge clk);
        opdata1_i = 32'hFFFFFFFF;
        opdata2_i = 32'd1;
        start_i   = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst", {ready_o, busy_o, result_o[61:0]}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_div("umax",   1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 34);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
